// File: rtl/ce_strobe_pkg.sv
// Shared state encoding and parameter limits for the CE strobe generator.
package ce_strobe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SLIP = 2'd2
  } ceStateE;

  localparam int DIV_MODE_MIN   = 1;
  localparam int DIV_MODE_MAX   = 16;
  localparam int INIT_DELAY_MIN = 0;
  localparam int INIT_DELAY_MAX = 15;

  localparam int PHASE_W = 4;
  localparam int WAIT_W  = 4;

endpackage

// File: rtl/ce_strobe_gen_if.sv
// Strobe bus: the generator (master) drives CE/PHASE/LOCK and samples CALIB.
interface ce_strobe_gen_if;
  import ce_strobe_pkg::*;

  logic               CALIB;
  logic               CE;
  logic [PHASE_W-1:0] PHASE;
  logic               LOCK;

  modport master (input CALIB, output CE, output PHASE, output LOCK);
  modport slave  (output CALIB, input CE, input PHASE, input LOCK);

endinterface

// File: rtl/ce_calib_edge.sv
// Falling-edge CALIB register with rise detect on the registered value.
module ce_calib_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic calib_i,
  output logic rise_o
);

  logic calib_q;
  logic calibPrev_q;

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      calib_q     <= 1'b0;
      calibPrev_q <= 1'b0;
    end else begin
      calib_q     <= calib_i;
      calibPrev_q <= calib_q;
    end
  end

  assign rise_o = calib_q & ~calibPrev_q;

endmodule

// File: rtl/ce_strobe_gen.sv
// Falling-edge CE strobe generator with start-up delay and LOCK indication.
// Define CE_STROBE_GEN_CALIB_EN to enable CALIB-driven one-cycle phase slips.
module ce_strobe_gen
  import ce_strobe_pkg::*;
#(
  parameter int DIV_MODE   = 4,
  parameter int INIT_DELAY = 0
) (
  input logic             CLK,
  input logic             RESET,
  ce_strobe_gen_if.master bus
);

  if (DIV_MODE < DIV_MODE_MIN || DIV_MODE > DIV_MODE_MAX) begin : gBadDivMode
    $fatal(1, "ce_strobe_gen: DIV_MODE=%0d outside %0d..%0d", DIV_MODE, DIV_MODE_MIN, DIV_MODE_MAX);
  end
  if (INIT_DELAY < INIT_DELAY_MIN || INIT_DELAY > INIT_DELAY_MAX) begin : gBadInitDelay
    $fatal(1, "ce_strobe_gen: INIT_DELAY=%0d outside %0d..%0d", INIT_DELAY, INIT_DELAY_MIN, INIT_DELAY_MAX);
  end

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DIV_MODE - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(INIT_DELAY);

  ceStateE            state_q, state_d;
  logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               ce_q, ce_d;
  logic               lock_q, lock_d;
  logic               calibRise;

`ifdef CE_STROBE_GEN_CALIB_EN
  ce_calib_edge u_calibEdge (
    .CLK     (CLK),
    .RESET   (RESET),
    .calib_i (bus.CALIB),
    .rise_o  (calibRise)
  );
`else
  logic unusedCalib;
  assign unusedCalib = bus.CALIB;
  assign calibRise   = 1'b0;
`endif

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      phase_q   <= '0;
      ce_q      <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      phase_q   <= phase_d;
      ce_q      <= ce_d;
      lock_q    <= lock_d;
    end
  end

  // A rise seen in SLIP (or IDLE) is dropped rather than queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (waitCnt_q == WAIT_LAST) state_d = RUN;
      RUN:     if (calibRise) state_d = SLIP;
      SLIP:    state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // The edge leaving SLIP already advances the divider, so a slip costs exactly one cycle.
  always_comb begin
    waitCnt_d = waitCnt_q;
    phase_d   = phase_q;
    ce_d      = 1'b0;
    lock_d    = lock_q;
    unique case (state_q)
      IDLE: begin
        if (waitCnt_q == WAIT_LAST) begin
          phase_d = '0;
          lock_d  = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      RUN, SLIP: begin
        if (state_q == RUN && calibRise) begin
          phase_d = phase_q;
        end else if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          ce_d    = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        waitCnt_d = '0;
        phase_d   = '0;
        lock_d    = 1'b0;
      end
    endcase
  end

  assign bus.CE    = ce_q;
  assign bus.PHASE = phase_q;
  assign bus.LOCK  = lock_q;

endmodule

// File: tb/tb_ce_strobe_gen.sv
// Randomised self-checking bench for ce_strobe_gen across several DIV_MODE/INIT_DELAY builds.
module tb_ce_strobe_gen;

  localparam int NI = 5;
  localparam int DIVS  [NI] = '{4, 1, 2, 7, 16};
  localparam int INITS [NI] = '{3, 0, 5, 15, 1};

`ifdef CE_STROBE_GEN_CALIB_EN
  localparam bit CALIB_ON = 1'b1;
`else
  localparam bit CALIB_ON = 1'b0;
`endif

  logic       CLK;
  logic       RESET;
  logic       CALIB;
  logic [5:0] obs [NI];

  int cmpCount = 0;
  int errCount = 0;

  // Reference model: edges waited, advancing edges since lock, and whether the last edge was a slip.
  int mWait [NI];
  int mAdv  [NI];
  int mPhase[NI];
  bit mLock [NI];
  bit mCe   [NI];
  bit mSlipLast[NI];
  bit mCalReg, mCalPrev;

  for (genvar g = 0; g < NI; g++) begin : gDut
    ce_strobe_gen_if ifc ();
    assign ifc.CALIB = CALIB;
    ce_strobe_gen #(.DIV_MODE(DIVS[g]), .INIT_DELAY(INITS[g])) u_dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (ifc)
    );
    assign obs[g] = {ifc.LOCK, ifc.CE, ifc.PHASE};
  end

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [5:0] expOf(int i);
    return {mLock[i], mCe[i], 4'(mPhase[i])};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NI; i++) begin
      mWait[i] = 0; mAdv[i] = 0; mPhase[i] = 0;
      mLock[i] = 0; mCe[i] = 0; mSlipLast[i] = 0;
    end
    mCalReg  = 0;
    mCalPrev = 0;
  endtask

  task automatic modelEdge();
    bit rise;
    rise = CALIB_ON && mCalReg && !mCalPrev;
    for (int i = 0; i < NI; i++) begin
      if (!mLock[i]) begin
        if (mWait[i] == INITS[i]) begin
          mLock[i] = 1; mAdv[i] = 0; mPhase[i] = 0;
        end else begin
          mWait[i]++;
        end
        mCe[i] = 0;
        mSlipLast[i] = 0;
      end else if (rise && !mSlipLast[i]) begin
        mSlipLast[i] = 1;
        mCe[i] = 0;
      end else begin
        mSlipLast[i] = 0;
        mAdv[i]++;
        mPhase[i] = mAdv[i] % DIVS[i];
        mCe[i] = (mPhase[i] == 0);
      end
    end
    mCalPrev = mCalReg;
    mCalReg  = CALIB;
  endtask

  // One falling edge; inputs change and outputs are sampled on the rising edge.
  task automatic tick();
    @(negedge CLK);
    if (!RESET) modelEdge();
    @(posedge CLK);
  endtask

  task automatic test_reset();
    int firstLock, firstCe;
    logic [3:0] phHist [32];
    int expPh [5];
    expPh = '{0, 1, 2, 3, 0};
    RESET = 1'b1;
    CALIB = 1'b0;
    modelReset();
    @(posedge CLK);
    for (int c = 0; c < 3; c++) begin
      #2;
      for (int i = 0; i < NI; i++) begin
        cmpCount++;
        if (obs[i] !== 6'd0) begin
          errCount++;
          $display("[TB] FAIL reset_hold inst%0d: got %b want %b", i, obs[i], 6'd0);
        end
      end
      tick();
    end
    RESET = 1'b0;
    firstLock = -1;
    firstCe   = -1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      phHist[e] = obs[0][3:0];
      if (firstLock < 0 && obs[0][5]) firstLock = e;
      if (firstCe < 0 && obs[0][4]) firstCe = e;
      for (int i = 0; i < NI; i++) begin
        cmpCount++;
        if (obs[i] !== expOf(i)) begin
          errCount++;
          $display("[TB] FAIL startup inst%0d edge%0d: got %b want %b", i, e, obs[i], expOf(i));
        end
      end
    end
    cmpCount++;
    if (firstLock !== 4) begin
      errCount++;
      $display("[TB] FAIL lock_edge: got %0d want 4", firstLock);
    end
    cmpCount++;
    if (firstCe !== 8) begin
      errCount++;
      $display("[TB] FAIL first_ce_edge: got %0d want 8", firstCe);
    end
    for (int k = 0; k < 5; k++) begin
      cmpCount++;
      if (phHist[4 + k] !== 4'(expPh[k])) begin
        errCount++;
        $display("[TB] FAIL startup_phase idx%0d: got %0d want %0d", k, phHist[4 + k], expPh[k]);
      end
    end
  endtask

  task automatic test_period_sweep();
    int ceCnt [NI];
    int diff;
    CALIB = 1'b0;
    for (int i = 0; i < NI; i++) ceCnt[i] = 0;
    for (int c = 0; c < 64; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        if (obs[i][4]) ceCnt[i]++;
        cmpCount++;
        if (obs[i] !== expOf(i)) begin
          errCount++;
          $display("[TB] FAIL sweep inst%0d cyc%0d: got %b want %b", i, c, obs[i], expOf(i));
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      diff = ceCnt[i] - 64 / DIVS[i];
      cmpCount++;
      if (diff < -1 || diff > 1 || (DIVS[i] == 1 && ceCnt[i] != 64)) begin
        errCount++;
        $display("[TB] FAIL ce_count div%0d: got %0d want %0d", DIVS[i], ceCnt[i], 64 / DIVS[i]);
      end
    end
  endtask

  task automatic test_slip();
    logic [3:0] ph [12];
    logic [8:0] ceSeen;
    logic [8:0] ceWant;
    int expPh [5];
    bit found;
    if (CALIB_ON) expPh = '{1, 2, 2, 3, 0};
    else          expPh = '{1, 2, 3, 0, 1};
    ceWant = CALIB_ON ? 9'b1_0001_0000 : 9'b0_1000_1000;
    CALIB = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (obs[0][3:0] == 4'd1) found = 1;
    end
    cmpCount++;
    if (!found) begin
      errCount++;
      $display("[TB] FAIL slip_wait: got no PHASE=1 within 20 edges, want PHASE=1");
      return;
    end
    ph[0] = obs[0][3:0];
    ceSeen = '0;
    ceSeen[0] = obs[0][4];
    CALIB = 1'b1;
    for (int j = 1; j < 12; j++) begin
      tick();
      CALIB = 1'b0;
      ph[j] = obs[0][3:0];
      if (j < 9) ceSeen[j] = obs[0][4];
      for (int i = 0; i < NI; i++) begin
        cmpCount++;
        if (obs[i] !== expOf(i)) begin
          errCount++;
          $display("[TB] FAIL slip inst%0d step%0d: got %b want %b", i, j, obs[i], expOf(i));
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      cmpCount++;
      if (ph[k] !== 4'(expPh[k])) begin
        errCount++;
        $display("[TB] FAIL slip_phase idx%0d: got %0d want %0d", k, ph[k], expPh[k]);
      end
    end
    cmpCount++;
    if (ceSeen !== ceWant) begin
      errCount++;
      $display("[TB] FAIL slip_ce_spacing: got %b want %b", ceSeen, ceWant);
    end
  endtask

  task automatic test_collision();
    logic [15:0] phSeen, phWant;
    logic [3:0]  ceSeen, ceWant;
    bit found;
    phWant = CALIB_ON ? {4'd2, 4'd3, 4'd3, 4'd0} : {4'd2, 4'd3, 4'd0, 4'd1};
    ceWant = CALIB_ON ? 4'b0001 : 4'b0010;
    CALIB = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (obs[0][3:0] == 4'd2) found = 1;
    end
    cmpCount++;
    if (!found) begin
      errCount++;
      $display("[TB] FAIL collision_wait: got no PHASE=2 within 20 edges, want PHASE=2");
      return;
    end
    phSeen = {obs[0][3:0], 12'd0};
    ceSeen = {obs[0][4], 3'd0};
    CALIB = 1'b1;
    for (int j = 1; j < 4; j++) begin
      tick();
      CALIB = 1'b0;
      phSeen[15 - 4 * j -: 4] = obs[0][3:0];
      ceSeen[3 - j] = obs[0][4];
      for (int i = 0; i < NI; i++) begin
        cmpCount++;
        if (obs[i] !== expOf(i)) begin
          errCount++;
          $display("[TB] FAIL collision inst%0d step%0d: got %b want %b", i, j, obs[i], expOf(i));
        end
      end
    end
    cmpCount++;
    if (phSeen !== phWant || ceSeen !== ceWant) begin
      errCount++;
      $display("[TB] FAIL collision_seq: got ph=%h ce=%b want ph=%h ce=%b", phSeen, ceSeen, phWant, ceWant);
    end
  endtask

  task automatic test_ignored_edges();
    logic [5:0] at5, at8;
    RESET = 1'b1;
    modelReset();
    tick();
    tick();
    RESET = 1'b0;
    for (int e = 1; e <= 48; e++) begin
      if (e <= 3)       CALIB = e[0];
      else if (e <= 8)  CALIB = 1'b0;
      else              CALIB = 1'($urandom_range(0, 1));
      tick();
      if (e == 5) at5 = obs[0];
      if (e == 8) at8 = obs[0];
      for (int i = 0; i < NI; i++) begin
        cmpCount++;
        if (obs[i] !== expOf(i)) begin
          errCount++;
          $display("[TB] FAIL ignored inst%0d edge%0d: got %b want %b", i, e, obs[i], expOf(i));
        end
      end
    end
    CALIB = 1'b0;
    cmpCount++;
    if (at5 !== 6'b10_0001 || at8 !== 6'b11_0000) begin
      errCount++;
      $display("[TB] FAIL idle_calib_ignored: got e5=%b e8=%b want e5=100001 e8=110000", at5, at8);
    end
  endtask

  task automatic test_async_reset();
    bit lockedAt4;
    CALIB = 1'b0;
    tick();
    tick();
    CALIB = 1'b1;
    tick();
    CALIB = 1'b0;
    tick();
    #2 RESET = 1'b1;
    modelReset();
    #1;
    for (int i = 0; i < NI; i++) begin
      cmpCount++;
      if (obs[i] !== 6'd0) begin
        errCount++;
        $display("[TB] FAIL async_reset inst%0d: got %b want %b", i, obs[i], 6'd0);
      end
    end
    @(posedge CLK);
    tick();
    RESET = 1'b0;
    lockedAt4 = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 3 && obs[0][5]) lockedAt4 = 0;
      if (e == 4) lockedAt4 = obs[0][5];
      for (int i = 0; i < NI; i++) begin
        cmpCount++;
        if (obs[i] !== expOf(i)) begin
          errCount++;
          $display("[TB] FAIL restart inst%0d edge%0d: got %b want %b", i, e, obs[i], expOf(i));
        end
      end
    end
    cmpCount++;
    if (lockedAt4 !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL restart_lock_edge4: got %b want 1", lockedAt4);
    end
  endtask

  initial begin
    RESET = 1'b1;
    CALIB = 1'b0;
    test_reset();
    test_period_sweep();
    test_slip();
    test_collision();
    test_ignored_edges();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
